// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache for the fetch stage.
// Hits answer combinationally; misses refill over a req/ack handshake to backing memory.
module icache_responder #(
    parameter int unsigned LINES    = 16,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_address,
    output logic [31:0] instruction,
    output logic        i_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] miss_count,
    output logic        dbg_state
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [31:0]        data_mem [LINES];
    logic               stale;
    logic [29:0]        miss_addr;
    logic [IDX_W-1:0]   idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               hit, start_miss, fill;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^i_address[1:0];

    assign idx      = i_address[IDX_W+1:2];
    assign tag      = i_address[31:IDX_W+2];
    assign fill_idx = miss_addr[IDX_W-1:0];
    assign fill_tag = miss_addr[29:IDX_W];

    assign hit         = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag) && !flush && !rst;
    assign i_ready     = hit;
    assign instruction = hit ? data_mem[idx] : NOP_WORD;
    assign mem_addr    = {miss_addr, 2'b00};
    assign dbg_state   = (state == REFILL);

    // Memory handshake: mem_req and mem_addr stay stable from the first REFILL
    // cycle until the cycle mem_ack is high; that cycle consumes mem_rdata and
    // the request ends. mem_ack outside REFILL carries no meaning and is ignored.
    always_comb begin
        state_next = state;
        start_miss = 1'b0;
        fill       = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && !hit) begin
                    start_miss = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A flush that lands while a refill is in flight poisons that refill via
    // stale, so the returning word is stored but never marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            stale      <= 1'b0;
            miss_addr  <= '0;
            miss_count <= '0;
        end else begin
            if (flush) valid <= '0;
            if (flush && (state == REFILL)) stale <= 1'b1;
            if (start_miss) begin
                miss_addr  <= i_address[31:2];
                stale      <= 1'b0;
                miss_count <= miss_count + 16'd1;
            end
            if (fill) valid[fill_idx] <= !(stale || flush);
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed vector table, randomized run against a
// line-address reference model, and a miss-counter wrap sequence.
module tb_icache_responder;

    localparam int unsigned LINES    = 16;
    localparam int unsigned IDX_W    = $clog2(LINES);
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] i_address;
    logic [31:0] instruction;
    logic        i_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] miss_count;
    logic        dbg_state;

    icache_responder #(.LINES(LINES), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .rst(rst), .i_address(i_address), .instruction(instruction),
        .i_ready(i_ready), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .miss_count(miss_count),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic        flush;
        logic        ack;
        logic        rdy;
        logic [31:0] instr;
        logic        req;
        logic [31:0] maddr;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[$];

    // reference model: which word address each line holds, plus the pending refill
    logic [31:0] line_addr[int];
    bit          m_busy;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [15:0] m_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % LINES);
    endfunction

    function automatic bit model_hit(input logic r, input logic [31:0] a, input logic f);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return !r && !m_busy && !f && line_addr.exists(idx_of(w)) && (line_addr[idx_of(w)] == w);
    endfunction

    function automatic void model_step(input logic r, input logic [31:0] a, input logic f, input logic ak);
        bit h;
        h = model_hit(r, a, f);
        if (r) begin
            m_busy = 0; m_stale = 0; m_addr = 0; m_cnt = 0;
            line_addr.delete();
        end else if (!m_busy) begin
            if (f) line_addr.delete();
            else if (!h) begin
                m_busy = 1; m_stale = 0; m_addr = {a[31:2], 2'b00}; m_cnt = m_cnt + 16'd1;
            end
        end else begin
            if (f) begin
                line_addr.delete();
                m_stale = 1;
            end
            if (ak) begin
                if (m_stale) line_addr.delete(idx_of(m_addr));
                else         line_addr[idx_of(m_addr)] = m_addr;
                m_busy = 0;
            end
        end
    endfunction

    function automatic void add(input logic r, input logic [31:0] a, input logic f, input logic ak,
                                input logic rdy, input logic [31:0] ins, input logic req,
                                input logic [31:0] ma, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.addr = a; v.flush = f; v.ack = ak;
        v.rdy = rdy; v.instr = ins; v.req = req; v.maddr = ma; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: inputs applied just after the rising edge
    task automatic drive(input logic r, input logic [31:0] a, input logic f, input logic ak);
        rst       = r;
        i_address = a;
        flush     = f;
        mem_ack   = ak;
        mem_rdata = mem_word(m_addr);
    endtask

    task automatic run_row(input vec_t v);
        drive(v.rst, v.addr, v.flush, v.ack);
        @(negedge clk);
        chk("tbl_ready", {31'b0, i_ready}, {31'b0, v.rdy});
        chk("tbl_instr", instruction, v.instr);
        chk("tbl_req", {31'b0, mem_req}, {31'b0, v.req});
        chk("tbl_maddr", mem_addr, v.maddr);
        chk("tbl_count", {16'b0, miss_count}, {16'b0, v.cnt});
        @(posedge clk);
        model_step(v.rst, v.addr, v.flush, v.ack);
        #1;
    endtask

    task automatic run_model(input logic r, input logic [31:0] a, input logic f, input logic ak);
        bit h;
        drive(r, a, f, ak);
        @(negedge clk);
        h = model_hit(r, a, f);
        chk("rnd_ready", {31'b0, i_ready}, {31'b0, h});
        chk("rnd_instr", instruction, h ? mem_word({a[31:2], 2'b00}) : NOP_WORD);
        chk("rnd_req", {31'b0, mem_req}, {31'b0, m_busy});
        chk("rnd_state", {31'b0, dbg_state}, {31'b0, m_busy});
        chk("rnd_maddr", mem_addr, m_addr);
        chk("rnd_count", {16'b0, miss_count}, {16'b0, m_cnt});
        @(posedge clk);
        model_step(r, a, f, ak);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] t, i, lo;
        t  = 32'($urandom_range(0, 2));
        i  = 32'($urandom_range(0, 3));
        lo = 32'($urandom_range(0, 3));
        return (t << (IDX_W + 2)) | (i << 2) | lo;
    endfunction

    initial begin
        logic [31:0] cur_addr;
        logic        r, f, ak;
        bit          was_busy;
        int          wait_left;

        m_busy = 0; m_stale = 0; m_addr = 0; m_cnt = 0;
        rst = 1'b1; i_address = 32'h0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        @(posedge clk);
        #1;

        //  rst  addr          fl ak   rdy instr                  req maddr          cnt
        add(1, 32'h40,  0, 0,  0, NOP_WORD,              0, 32'h0,   16'd0);
        // cold miss, memory wait 3
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              0, 32'h0,   16'd0);
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              1, 32'h40,  16'd1);
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              1, 32'h40,  16'd1);
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              1, 32'h40,  16'd1);
        add(0, 32'h40,  0, 1,  0, NOP_WORD,              1, 32'h40,  16'd1);
        add(0, 32'h40,  0, 0,  1, 32'hDEADBEEF,          0, 32'h40,  16'd1);
        // zero-wait miss on 0x44, return to 0x40, conflict with 0x80
        add(0, 32'h44,  0, 0,  0, NOP_WORD,              0, 32'h40,  16'd1);
        add(0, 32'h44,  0, 1,  0, NOP_WORD,              1, 32'h44,  16'd2);
        add(0, 32'h44,  0, 0,  1, mem_word(32'h44),      0, 32'h44,  16'd2);
        add(0, 32'h40,  0, 0,  1, 32'hDEADBEEF,          0, 32'h44,  16'd2);
        add(0, 32'h80,  0, 0,  0, NOP_WORD,              0, 32'h44,  16'd2);
        add(0, 32'h80,  0, 1,  0, NOP_WORD,              1, 32'h80,  16'd3);
        add(0, 32'h80,  0, 0,  1, mem_word(32'h80),      0, 32'h80,  16'd3);
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              0, 32'h80,  16'd3);
        add(0, 32'h40,  0, 1,  0, NOP_WORD,              1, 32'h40,  16'd4);
        add(0, 32'h40,  0, 0,  1, 32'hDEADBEEF,          0, 32'h40,  16'd4);
        // flush in idle, flush during refill, flush together with ack
        add(0, 32'h40,  1, 0,  0, NOP_WORD,              0, 32'h40,  16'd4);
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              0, 32'h40,  16'd4);
        add(0, 32'h40,  1, 0,  0, NOP_WORD,              1, 32'h40,  16'd5);
        add(0, 32'h40,  0, 1,  0, NOP_WORD,              1, 32'h40,  16'd5);
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              0, 32'h40,  16'd5);
        add(0, 32'h40,  1, 1,  0, NOP_WORD,              1, 32'h40,  16'd6);
        add(0, 32'h40,  0, 0,  0, NOP_WORD,              0, 32'h40,  16'd6);
        add(0, 32'h40,  0, 1,  0, NOP_WORD,              1, 32'h40,  16'd7);
        add(0, 32'h40,  0, 0,  1, 32'hDEADBEEF,          0, 32'h40,  16'd7);
        // branch during refill: 0x100 outstanding, PC moves to 0x200
        add(0, 32'h100, 0, 0,  0, NOP_WORD,              0, 32'h40,  16'd7);
        add(0, 32'h200, 0, 0,  0, NOP_WORD,              1, 32'h100, 16'd8);
        add(0, 32'h200, 0, 1,  0, NOP_WORD,              1, 32'h100, 16'd8);
        add(0, 32'h100, 0, 0,  1, mem_word(32'h100),     0, 32'h100, 16'd8);
        add(0, 32'h200, 0, 0,  0, NOP_WORD,              0, 32'h100, 16'd8);
        add(0, 32'h200, 0, 1,  0, NOP_WORD,              1, 32'h200, 16'd9);
        add(0, 32'h200, 0, 0,  1, mem_word(32'h200),     0, 32'h200, 16'd9);
        // reset mid-refill, late ack ignored
        add(0, 32'h100, 0, 0,  0, NOP_WORD,              0, 32'h200, 16'd9);
        add(1, 32'h100, 0, 0,  0, NOP_WORD,              1, 32'h100, 16'd10);
        add(0, 32'h100, 0, 1,  0, NOP_WORD,              0, 32'h0,   16'd0);
        add(0, 32'h100, 0, 0,  0, NOP_WORD,              1, 32'h100, 16'd1);
        add(1, 32'h200, 0, 0,  0, NOP_WORD,              1, 32'h100, 16'd1);
        add(0, 32'h200, 0, 0,  0, NOP_WORD,              0, 32'h0,   16'd0);
        add(0, 32'h200, 0, 1,  0, NOP_WORD,              1, 32'h200, 16'd1);
        add(0, 32'h200, 0, 0,  1, mem_word(32'h200),     0, 32'h200, 16'd1);

        foreach (tbl[k]) run_row(tbl[k]);

        // randomized traffic against the model
        cur_addr  = rand_addr();
        wait_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 30) cur_addr = rand_addr();
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 99) < 3);
            ak = m_busy ? (wait_left == 0) : ($urandom_range(0, 9) == 0);
            was_busy = m_busy;
            run_model(r, cur_addr, f, ak);
            if (!was_busy && m_busy)  wait_left = $urandom_range(0, 3);
            else if (m_busy && !ak && wait_left > 0) wait_left--;
        end

        // miss counter wrap: 65536 zero-wait conflict misses after reset
        run_model(1'b1, 32'h40, 1'b0, 1'b0);
        rst = 1'b0; flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1;
        for (int i = 0; i < 65536; i++) begin
            i_address = i[0] ? 32'h80 : 32'h40;
            if (i == 65535) begin
                @(negedge clk);
                chk("count_ffff", {16'b0, miss_count}, 32'h0000FFFF);
            end
            @(posedge clk);
            #1;
            if (i == 65535) begin
                @(negedge clk);
                chk("count_wrap", {16'b0, miss_count}, 32'h0);
                chk("wrap_req", {31'b0, mem_req}, 32'h1);
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
